// File: rtl/parity_accum_pkg.sv
// Shared types and constants for parity_accum.
// Optional feature macro: PARITY_ACCUM_ERR_CHECK_EN (see parity_accum.sv).
package parity_accum_pkg;

  localparam int unsigned FRAMES_W = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/parity_accum_word_parity.sv
// Combinational per-word parity: XOR reduction of one input word.
module word_parity #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  // Odd number of set bits gives 1.
  always_comb parity = ^data;

endmodule

// File: rtl/parity_accum.sv
// Frame parity accumulator: XORs the parity of FRAME_LEN accepted words,
// presents the (optionally inverted) result until the consumer takes it,
// and counts completed frames.
// Optional feature: define PARITY_ACCUM_ERR_CHECK_EN to add exp_parity/err,
// a sticky flag set when a taken result differs from exp_parity.
module parity_accum
  import parity_accum_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned XNOR_MODE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_parity,
  output logic [FRAMES_W-1:0] out_frames
`ifdef PARITY_ACCUM_ERR_CHECK_EN
  ,
  input  logic                exp_parity,
  output logic                err
`endif
);

  localparam int unsigned      CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(FRAME_LEN);
  localparam logic             XNOR_BIT = (XNOR_MODE != 0);

  state_t           state, state_next;
  logic             acc, acc_next;
  logic [CNT_W-1:0] word_cnt, cnt_next, cnt_inc;
  logic             word_par;
  logic             frame_done;
  logic             handshake;

  word_parity #(.WIDTH(WIDTH)) u_word_parity (
    .data   (in_data),
    .parity (word_par)
  );

  // Next-state, accumulator and counter updates; handshake flags.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = word_cnt;
    cnt_inc    = word_cnt + CNT_W'(1);
    frame_done = 1'b0;
    handshake  = 1'b0;
    in_ready   = (state == ACCUM);
    out_valid  = (state == HOLD);
    case (state)
      ACCUM: begin
        if (in_abort) begin
          acc_next = 1'b0;
          cnt_next = '0;
        end else if (in_valid) begin
          acc_next = acc ^ word_par;
          cnt_next = cnt_inc;
          if (cnt_inc == LAST) begin
            state_next = HOLD;
            frame_done = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = ACCUM;
          acc_next   = 1'b0;
          cnt_next   = '0;
          handshake  = 1'b1;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // State, accumulator and word counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      acc      <= 1'b0;
      word_cnt <= '0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      word_cnt <= cnt_next;
    end
  end

  // Result latch on the last accepted word and completed-frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
      out_frames <= '0;
    end else begin
      if (frame_done) out_parity <= acc_next ^ XNOR_BIT;
      if (handshake)  out_frames <= out_frames + FRAMES_W'(1);
    end
  end

`ifdef PARITY_ACCUM_ERR_CHECK_EN
  // Sticky mismatch flag, evaluated when the consumer takes a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  err <= 1'b0;
    else if (handshake && (exp_parity != out_parity)) err <= 1'b1;
  end
`endif

endmodule
